// File: rtl/demux_1x2_8bit_fifo.sv
// -----------------------------------------------------------------------------
// demux_1x2_8bit_fifo
//
// Steers a single valid/ready byte stream to one of two output channels,
// chosen per beat by in_sel. Each channel owns a private FIFO, so a stalled
// consumer only backpressures beats addressed to its own channel.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears pointers and counts
//   in_data      producer byte
//   in_sel       destination channel (0 or 1)
//   in_valid     producer offers a beat
//   in_ready     addressed channel is not full (depends on in_sel only)
//   out0_data    channel 0 head, 0 when empty
//   out0_valid   channel 0 non-empty
//   out0_ready   consumer 0 takes the head
//   out1_data    channel 1 head, 0 when empty
//   out1_valid   channel 1 non-empty
//   out1_ready   consumer 1 takes the head
//   count0       channel 0 occupancy, 0..DEPTH
//   count1       channel 1 occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module demux_1x2_8bit_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_sel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out0_data,
   output logic                       out0_valid,
   input  logic                       out0_ready,
   output logic [WIDTH-1:0]           out1_data,
   output logic                       out1_valid,
   input  logic                       out1_ready,
   output logic [$clog2(DEPTH):0]     count0,
   output logic [$clog2(DEPTH):0]     count1
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Refuse to build with a depth the pointer arithmetic cannot wrap cleanly.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("demux_1x2_8bit_fifo: DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem    [2][DEPTH];
   logic [AW-1:0]    wr_ptr [2];
   logic [AW-1:0]    rd_ptr [2];
   logic [CW-1:0]    cnt    [2];

   logic [1:0] full;
   logic [1:0] valid;
   logic [1:0] push;
   logic [1:0] pop;

   always_comb begin
      // NOTE: every signal written here gets a default first so that no
      // path leaves it unassigned and a latch is never inferred.
      full  = '0;
      valid = '0;
      push  = '0;
      pop   = '0;
      for (int k = 0; k < 2; k++) begin
         full[k]  = (cnt[k] == FULL_CNT);
         valid[k] = (cnt[k] != '0);
      end
      // Ready is a function of the addressed channel alone; a pop in the
      // same cycle does not free space for a push into a full channel.
      in_ready       = ~full[in_sel];
      push[in_sel]   = in_valid & ~full[in_sel];
      pop[0]         = valid[0] & out0_ready;
      pop[1]         = valid[1] & out1_ready;
   end

   // NOTE: state registers use non-blocking assignments so all channels
   // update from the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            cnt[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
            if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
            case ({push[k], pop[k]})
               2'b10:   cnt[k] <= cnt[k] + CW'(1);
               2'b01:   cnt[k] <= cnt[k] - CW'(1);
               default: cnt[k] <= cnt[k];
            endcase
         end
      end
   end

   // NOTE: the storage array has no reset; validity comes from the counts,
   // and leaving it unreset lets it map onto plain RAM/flops without reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (push[k]) mem[k][wr_ptr[k]] <= in_data;
      end
   end

   // Empty channels present zero rather than whatever the head slot holds.
   assign out0_valid = valid[0];
   assign out1_valid = valid[1];
   assign out0_data  = valid[0] ? mem[0][rd_ptr[0]] : '0;
   assign out1_data  = valid[1] ? mem[1][rd_ptr[1]] : '0;
   assign count0     = cnt[0];
   assign count1     = cnt[1];

endmodule

// File: tb/tb_demux_1x2_8bit_fifo.sv
// -----------------------------------------------------------------------------
// tb_demux_1x2_8bit_fifo
//
// Self-checking bench for demux_1x2_8bit_fifo (WIDTH=8, DEPTH=4). A table of
// single-cycle vectors covers the single beat, fill/backpressure and the
// drain-with-wrap sequence; hand-written sequences cover full with
// simultaneous pop, alternating traffic and asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_demux_1x2_8bit_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out0_data;
   logic       out0_valid;
   logic       out0_ready;
   logic [7:0] out1_data;
   logic       out1_valid;
   logic       out1_ready;
   logic [2:0] count0;
   logic [2:0] count1;

   int n_checks = 0;
   int n_pass   = 0;

   demux_1x2_8bit_fifo #(.WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .count0     (count0),
      .count1     (count1)
   );

   always #5 clk = ~clk;

   // Inputs: sel, valid, data, r0, r1. Expected: rdy before the edge,
   // then channel state after the edge.
   typedef struct {
      logic       sel;
      logic       valid;
      logic [7:0] data;
      logic       r0;
      logic       r1;
      logic       rdy;
      logic       v0;
      logic [7:0] d0;
      logic [2:0] c0;
      logic       v1;
      logic [7:0] d1;
      logic [2:0] c1;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic sel, input logic valid, input logic [7:0] data,
                      input logic r0, input logic r1, input logic rdy,
                      input logic v0, input logic [7:0] d0, input logic [2:0] c0,
                      input logic v1, input logic [7:0] d1, input logic [2:0] c1);
      vec_t v;
      v.sel = sel; v.valid = valid; v.data = data; v.r0 = r0; v.r1 = r1;
      v.rdy = rdy; v.v0 = v0; v.d0 = d0; v.c0 = c0;
      v.v1 = v1; v.d1 = d1; v.c1 = c1;
      vecs.push_back(v);
   endtask

   task automatic check_state(input string tag,
                              input logic v0, input logic [7:0] d0, input logic [2:0] c0,
                              input logic v1, input logic [7:0] d1, input logic [2:0] c1);
      check({tag, "_v0"}, out0_valid, v0);
      check({tag, "_d0"}, out0_data,  d0);
      check({tag, "_c0"}, count0,     c0);
      check({tag, "_v1"}, out1_valid, v1);
      check({tag, "_d1"}, out1_data,  d1);
      check({tag, "_c1"}, count1,     c1);
   endtask

   task automatic drive(input logic sel, input logic valid, input logic [7:0] data,
                        input logic r0, input logic r1);
      in_sel = sel; in_valid = valid; in_data = data;
      out0_ready = r0; out1_ready = r1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // ---------------- vector table ----------------
      //   sel  val  data   r0 r1 | rdy | v0 d0    c0 | v1 d1    c1
      // single beat
      add(0, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1, 0, 8'h00, 0);
      add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0);
      // fill channel 0 with consumer 0 stalled
      add(0, 1, 8'h01, 0, 0, 1, 1, 8'h01, 1, 0, 8'h00, 0);
      add(0, 1, 8'h02, 0, 0, 1, 1, 8'h01, 2, 0, 8'h00, 0);
      add(0, 1, 8'h03, 0, 0, 1, 1, 8'h01, 3, 0, 8'h00, 0);
      add(0, 1, 8'h04, 0, 0, 1, 1, 8'h01, 4, 0, 8'h00, 0);
      // full: refused; channel 1 still open
      add(0, 1, 8'h99, 0, 0, 0, 1, 8'h01, 4, 0, 8'h00, 0);
      add(1, 1, 8'h77, 0, 0, 1, 1, 8'h01, 4, 1, 8'h77, 1);
      add(1, 0, 8'h00, 0, 1, 1, 1, 8'h01, 4, 0, 8'h00, 0);
      // drain channel 0 in order
      add(0, 0, 8'h00, 1, 0, 0, 1, 8'h02, 3, 0, 8'h00, 0);
      add(0, 0, 8'h00, 1, 0, 1, 1, 8'h03, 2, 0, 8'h00, 0);
      add(0, 0, 8'h00, 1, 0, 1, 1, 8'h04, 1, 0, 8'h00, 0);
      add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0);
      // streaming through the wrap point with continuous pops
      add(0, 1, 8'h10, 1, 0, 1, 1, 8'h10, 1, 0, 8'h00, 0);
      add(0, 1, 8'h11, 1, 0, 1, 1, 8'h11, 1, 0, 8'h00, 0);
      add(0, 1, 8'h12, 1, 0, 1, 1, 8'h12, 1, 0, 8'h00, 0);
      add(0, 1, 8'h13, 1, 0, 1, 1, 8'h13, 1, 0, 8'h00, 0);
      add(0, 1, 8'h14, 1, 0, 1, 1, 8'h14, 1, 0, 8'h00, 0);
      add(0, 1, 8'h15, 1, 0, 1, 1, 8'h15, 1, 0, 8'h00, 0);
      add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0);

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_in_ready", in_ready, 1'b1);
      check_state("rst", 0, 8'h00, 0, 0, 8'h00, 0);
      reset = 1'b0;

      // ---------------- table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].r0, vecs[i].r1);
         #1;
         check($sformatf("vec%0d_rdy", i), in_ready, vecs[i].rdy);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].v0, vecs[i].d0, vecs[i].c0,
                     vecs[i].v1, vecs[i].d1, vecs[i].c1);
      end

      // ---------------- full channel 1 with simultaneous pop ----------------
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
         tick();
      end
      check("full1_c1", count1, 3'd4);
      drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
      #1;
      check("full1_rdy", in_ready, 1'b0);
      tick();
      check("full1_pop_c1", count1, 3'd3);
      check("full1_pop_d1", out1_data, 8'h21);
      check("full1_rdy_after", in_ready, 1'b1);
      out1_ready = 1'b0;
      tick();
      check("full1_acc_c1", count1, 3'd4);
      check("full1_acc_d1", out1_data, 8'h21);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      tick(); check("full1_drain_a", out1_data, 8'h22);
      tick(); check("full1_drain_b", out1_data, 8'h23);
      tick(); check("full1_drain_c", out1_data, 8'hEE);
      tick(); check("full1_empty", out1_valid, 1'b0);

      // ---------------- alternating independent traffic ----------------
      for (int i = 0; i < 20; i++) begin
         drive(i[0], 1'b1, 8'(8'h40 + i), 1'b1, 1'b1);
         tick();
         if (i[0] == 1'b0) begin
            check($sformatf("alt%0d_d0", i), out0_data, 8'(8'h40 + i));
            check($sformatf("alt%0d_c0", i), count0, 3'd1);
            check($sformatf("alt%0d_c1", i), count1, (i == 0) ? 3'd0 : 3'd0);
         end else begin
            check($sformatf("alt%0d_d1", i), out1_data, 8'(8'h40 + i));
            check($sformatf("alt%0d_c1", i), count1, 3'd1);
            check($sformatf("alt%0d_c0", i), count0, 3'd0);
         end
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      tick();
      check_state("alt_end", 0, 8'h00, 0, 0, 8'h00, 0);

      // ---------------- async reset mid-stream ----------------
      drive(1'b0, 1'b1, 8'h50, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 8'h51, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 8'h60, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 8'h61, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("pre_rst_c0", count0, 3'd2);
      check("pre_rst_c1", count1, 3'd2);
      #2;
      reset = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1'b1);
      check_state("arst", 0, 8'h00, 0, 0, 8'h00, 0);
      tick();
      reset = 1'b0;
      drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check_state("post_rst", 0, 8'h00, 0, 1, 8'h3C, 1);
      out1_ready = 1'b1;
      tick();
      check("post_rst_drained", out1_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
